hazard_ctrl: RTL and testbench

Parametrised pipeline hazard controller for the 5-stage MIPS core, replacing the single-purpose `Hazard` block. It generates every stall, flush and forwarding select from stage register fields in one place. It adds multi-cycle data-memory wait states, branch-operand stalls for ID-stage branch resolution, and a saturating stall-cycle counter. It sits beside the pipeline registers in `pipeline` and drives their hold/flush pins and the forwarding muxes.

---
 rtl/hazard_ctrl_pkg.sv | 26 ++
 rtl/hazard_ctrl_if.sv | 59 +++++
 rtl/hazard_ctrl_mem_wait_fsm.sv | 75 +++++++
 rtl/hazard_ctrl.sv | 105 ++++++++++
 tb/tb_hazard_ctrl.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline constants: EX forwarding selects and the memory-wait FSM states.
// Also imported by the pipeline datapath, so the encodings here are part of its contract.
package pipe_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_t;

    // The younger result (EX/MEM) wins over the older one (MEM/WB).
    function automatic logic [1:0] fwd_sel(input logic mem_hit, input logic wb_hit);
        logic [1:0] sel;
        sel = FWD_RF;
        if (mem_hit) begin
            sel = FWD_MEM;
        end else if (wb_hit) begin
            sel = FWD_WB;
        end
        return sel;
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Bundle of stage-register fields seen by the hazard controller and the
// hold/flush/forward controls it returns to the pipeline.
interface hazard_ctrl_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
);
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic              id_use_rt;
    logic              id_branch;
    logic              id_taken;
    logic              id_jump;
    logic [REG_AW-1:0] ex_rs;
    logic [REG_AW-1:0] ex_rt;
    logic [REG_AW-1:0] ex_rd;
    logic              ex_memread;
    logic              ex_regwrite;
    logic [REG_AW-1:0] mem_rd;
    logic              mem_memread;
    logic              mem_memwrite;
    logic              mem_regwrite;
    logic [REG_AW-1:0] wb_rd;
    logic              wb_regwrite;

    logic              pc_hold;
    logic              if_id_hold;
    logic              id_ex_hold;
    logic              ex_mem_hold;
    logic              if_id_flush;
    logic              id_ex_bubble;
    logic              mem_wb_bubble;
    logic [1:0]        fwd_a;
    logic [1:0]        fwd_b;
    logic              fwd_id_a;
    logic              fwd_id_b;
    logic              mem_busy;
    logic [CNT_W-1:0]  stall_cycles;

    modport master (
        output id_rs, id_rt, id_use_rt, id_branch, id_taken, id_jump,
        output ex_rs, ex_rt, ex_rd, ex_memread, ex_regwrite,
        output mem_rd, mem_memread, mem_memwrite, mem_regwrite,
        output wb_rd, wb_regwrite,
        input  pc_hold, if_id_hold, id_ex_hold, ex_mem_hold,
        input  if_id_flush, id_ex_bubble, mem_wb_bubble,
        input  fwd_a, fwd_b, fwd_id_a, fwd_id_b, mem_busy, stall_cycles
    );

    modport slave (
        input  id_rs, id_rt, id_use_rt, id_branch, id_taken, id_jump,
        input  ex_rs, ex_rt, ex_rd, ex_memread, ex_regwrite,
        input  mem_rd, mem_memread, mem_memwrite, mem_regwrite,
        input  wb_rd, wb_regwrite,
        output pc_hold, if_id_hold, id_ex_hold, ex_mem_hold,
        output if_id_flush, id_ex_bubble, mem_wb_bubble,
        output fwd_a, fwd_b, fwd_id_a, fwd_id_b, mem_busy, stall_cycles
    );

endinterface

// File: rtl/hazard_ctrl_mem_wait_fsm.sv
// Multi-cycle data-memory wait tracker: freezes the pipeline for MEM_LAT-1 cycles
// per access and remembers a completed access so it does not re-trigger.
module mem_wait_fsm
    import pipe_pkg::*;
#(
    parameter int MEM_LAT = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic access,
    output logic freeze,
    output logic busy
);

    localparam int CW = 4;
    localparam bit MULTI_CYCLE = (MEM_LAT > 1);
    localparam bit NEEDS_WAIT  = (MEM_LAT > 2);
    // The detect cycle is the first freeze cycle, so WAIT covers the remaining MEM_LAT-2.
    localparam logic [CW-1:0] WAIT_LOAD = NEEDS_WAIT ? CW'(MEM_LAT - 2) : '0;

    mem_state_t    state, state_next;
    logic [CW-1:0] cnt, cnt_next;
    logic          done, done_next;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            done  <= done_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        done_next  = done;
        freeze     = 1'b0;
        case (state)
            IDLE: begin
                if (MULTI_CYCLE && access && !done) begin
                    freeze = 1'b1;
                    if (NEEDS_WAIT) begin
                        state_next = WAIT;
                        cnt_next   = WAIT_LOAD;
                    end else begin
                        done_next = 1'b1;
                    end
                end else if (done) begin
                    // EX/MEM advances this cycle, so the finished access leaves MEM.
                    done_next = 1'b0;
                end
            end
            WAIT: begin
                freeze = 1'b1;
                if (cnt == CW'(1)) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                    done_next  = 1'b1;
                end else begin
                    cnt_next = cnt - CW'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy = (state == WAIT);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: forwarding selects, load-use and branch-operand
// stalls, control-transfer flush, memory wait freeze and a saturating stall counter.
module hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int REG_AW  = 5,
    parameter int MEM_LAT = 1,
    parameter int CNT_W   = 16
) (
    input  logic         clk,
    input  logic         reset,
    hazard_ctrl_if.slave hz
);

    localparam logic [REG_AW-1:0] R0 = '0;

    logic             mem_access;
    logic             freeze;
    logic             busy;
    logic             ex_a_mem, ex_a_wb, ex_b_mem, ex_b_wb;
    logic             id_a_mem, id_b_mem;
    logic             load_use;
    logic             br_ex_hit, br_mem_hit, branch_stall;
    logic             stall;
    logic             redirect;
    logic             hold_front;
    logic [CNT_W-1:0] stall_cnt;

    assign mem_access = hz.mem_memread || hz.mem_memwrite;

    mem_wait_fsm #(
        .MEM_LAT(MEM_LAT)
    ) u_mem_wait (
        .clk   (clk),
        .reset (reset),
        .access(mem_access),
        .freeze(freeze),
        .busy  (busy)
    );

    assign ex_a_mem = hz.mem_regwrite && (hz.mem_rd != R0) && (hz.mem_rd == hz.ex_rs);
    assign ex_b_mem = hz.mem_regwrite && (hz.mem_rd != R0) && (hz.mem_rd == hz.ex_rt);
    assign ex_a_wb  = hz.wb_regwrite  && (hz.wb_rd  != R0) && (hz.wb_rd  == hz.ex_rs);
    assign ex_b_wb  = hz.wb_regwrite  && (hz.wb_rd  != R0) && (hz.wb_rd  == hz.ex_rt);

    // A load in MEM has no data yet, so the ID comparator may only take ALU results.
    assign id_a_mem = hz.mem_regwrite && !hz.mem_memread && (hz.mem_rd != R0)
                      && (hz.mem_rd == hz.id_rs);
    assign id_b_mem = hz.mem_regwrite && !hz.mem_memread && (hz.mem_rd != R0)
                      && (hz.mem_rd == hz.id_rt);

    assign load_use = hz.ex_memread && (hz.ex_rd != R0)
                      && ((hz.ex_rd == hz.id_rs) || (hz.id_use_rt && (hz.ex_rd == hz.id_rt)));

    assign br_ex_hit  = hz.ex_regwrite && (hz.ex_rd != R0)
                        && ((hz.ex_rd == hz.id_rs) || (hz.ex_rd == hz.id_rt));
    assign br_mem_hit = hz.mem_memread && (hz.mem_rd != R0)
                        && ((hz.mem_rd == hz.id_rs) || (hz.mem_rd == hz.id_rt));
    assign branch_stall = hz.id_branch && (br_ex_hit || br_mem_hit);

    assign stall      = load_use || branch_stall;
    assign redirect   = (hz.id_branch && hz.id_taken) || hz.id_jump;
    assign hold_front = reset && (freeze || stall);

    // Freeze outranks stall, which outranks flush; everything reads 0 while in reset.
    always_comb begin
        hz.pc_hold       = 1'b0;
        hz.if_id_hold    = 1'b0;
        hz.id_ex_hold    = 1'b0;
        hz.ex_mem_hold   = 1'b0;
        hz.if_id_flush   = 1'b0;
        hz.id_ex_bubble  = 1'b0;
        hz.mem_wb_bubble = 1'b0;
        hz.fwd_a         = FWD_RF;
        hz.fwd_b         = FWD_RF;
        hz.fwd_id_a      = 1'b0;
        hz.fwd_id_b      = 1'b0;
        hz.mem_busy      = 1'b0;
        if (reset) begin
            hz.pc_hold       = freeze || stall;
            hz.if_id_hold    = freeze || stall;
            hz.id_ex_hold    = freeze;
            hz.ex_mem_hold   = freeze;
            hz.mem_wb_bubble = freeze;
            hz.id_ex_bubble  = stall && !freeze;
            hz.if_id_flush   = redirect && !stall && !freeze;
            hz.fwd_a         = fwd_sel(ex_a_mem, ex_a_wb);
            hz.fwd_b         = fwd_sel(ex_b_mem, ex_b_wb);
            hz.fwd_id_a      = id_a_mem;
            hz.fwd_id_b      = id_b_mem;
            hz.mem_busy      = busy;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
        end else if (hold_front && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    assign hz.stall_cycles = stall_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: one single-cycle-memory instance and one
// MEM_LAT=4 / CNT_W=4 instance, driven by directed vectors with hand-computed results.
module tb_hazard_ctrl;
    import pipe_pkg::*;

    typedef struct packed {
        logic [4:0] id_rs;
        logic [4:0] id_rt;
        logic       id_use_rt;
        logic       id_branch;
        logic       id_taken;
        logic       id_jump;
        logic [4:0] ex_rs;
        logic [4:0] ex_rt;
        logic [4:0] ex_rd;
        logic       ex_memread;
        logic       ex_regwrite;
        logic [4:0] mem_rd;
        logic       mem_memread;
        logic       mem_memwrite;
        logic       mem_regwrite;
        logic [4:0] wb_rd;
        logic       wb_regwrite;
    } in_t;

    // ctl = {pc_hold, if_id_hold, id_ex_hold, ex_mem_hold, if_id_flush, id_ex_bubble, mem_wb_bubble}
    typedef struct packed {
        logic [6:0]  ctl;
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic        fia;
        logic        fib;
        logic        busy;
        logic [15:0] cnt;
    } out_t;

    typedef struct {
        string name;
        bit    sel;
        out_t  exp;
    } sb_t;

    localparam logic [6:0] NONE   = 7'b0000000;
    localparam logic [6:0] STALL  = 7'b1100010;
    localparam logic [6:0] FREEZE = 7'b1111001;
    localparam logic [6:0] FLUSH  = 7'b0000100;

    logic clk = 1'b0;
    logic reset_a;
    logic reset_b;
    int   compared = 0;
    int   failed   = 0;
    sb_t  sb_q[$];
    out_t obs_a, obs_b;

    always #5 clk = ~clk;

    hazard_ctrl_if #(.REG_AW(5), .CNT_W(16)) hif_a ();
    hazard_ctrl_if #(.REG_AW(5), .CNT_W(4))  hif_b ();

    hazard_ctrl #(.REG_AW(5), .MEM_LAT(1), .CNT_W(16)) u_dut_a (
        .clk  (clk),
        .reset(reset_a),
        .hz   (hif_a.slave)
    );

    hazard_ctrl #(.REG_AW(5), .MEM_LAT(4), .CNT_W(4)) u_dut_b (
        .clk  (clk),
        .reset(reset_b),
        .hz   (hif_b.slave)
    );

    assign obs_a = {hif_a.pc_hold, hif_a.if_id_hold, hif_a.id_ex_hold, hif_a.ex_mem_hold,
                    hif_a.if_id_flush, hif_a.id_ex_bubble, hif_a.mem_wb_bubble,
                    hif_a.fwd_a, hif_a.fwd_b, hif_a.fwd_id_a, hif_a.fwd_id_b,
                    hif_a.mem_busy, hif_a.stall_cycles};
    assign obs_b = {hif_b.pc_hold, hif_b.if_id_hold, hif_b.id_ex_hold, hif_b.ex_mem_hold,
                    hif_b.if_id_flush, hif_b.id_ex_bubble, hif_b.mem_wb_bubble,
                    hif_b.fwd_a, hif_b.fwd_b, hif_b.fwd_id_a, hif_b.fwd_id_b,
                    hif_b.mem_busy, 12'd0, hif_b.stall_cycles};

    task automatic driveIf(input bit sel, input in_t v);
        if (!sel) begin
            hif_a.id_rs = v.id_rs;             hif_a.id_rt = v.id_rt;
            hif_a.id_use_rt = v.id_use_rt;     hif_a.id_branch = v.id_branch;
            hif_a.id_taken = v.id_taken;       hif_a.id_jump = v.id_jump;
            hif_a.ex_rs = v.ex_rs;             hif_a.ex_rt = v.ex_rt;
            hif_a.ex_rd = v.ex_rd;             hif_a.ex_memread = v.ex_memread;
            hif_a.ex_regwrite = v.ex_regwrite; hif_a.mem_rd = v.mem_rd;
            hif_a.mem_memread = v.mem_memread; hif_a.mem_memwrite = v.mem_memwrite;
            hif_a.mem_regwrite = v.mem_regwrite;
            hif_a.wb_rd = v.wb_rd;             hif_a.wb_regwrite = v.wb_regwrite;
        end else begin
            hif_b.id_rs = v.id_rs;             hif_b.id_rt = v.id_rt;
            hif_b.id_use_rt = v.id_use_rt;     hif_b.id_branch = v.id_branch;
            hif_b.id_taken = v.id_taken;       hif_b.id_jump = v.id_jump;
            hif_b.ex_rs = v.ex_rs;             hif_b.ex_rt = v.ex_rt;
            hif_b.ex_rd = v.ex_rd;             hif_b.ex_memread = v.ex_memread;
            hif_b.ex_regwrite = v.ex_regwrite; hif_b.mem_rd = v.mem_rd;
            hif_b.mem_memread = v.mem_memread; hif_b.mem_memwrite = v.mem_memwrite;
            hif_b.mem_regwrite = v.mem_regwrite;
            hif_b.wb_rd = v.wb_rd;             hif_b.wb_regwrite = v.wb_regwrite;
        end
    endtask

    // Called just after a rising edge; the monitor checks the entry on the next falling edge.
    task automatic applyStimulus(input string name, input bit sel, input logic rst, input in_t v,
                                 input logic [6:0] ctl, input logic [1:0] fa, input logic [1:0] fb,
                                 input logic fia, input logic fib, input logic busy,
                                 input int unsigned cnt);
        sb_t e;
        if (!sel) reset_a = rst;
        else      reset_b = rst;
        driveIf(sel, v);
        e.name = name;
        e.sel  = sel;
        e.exp  = {ctl, fa, fb, fia, fib, busy, 16'(cnt)};
        sb_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input sb_t e);
        out_t got;
        got = e.sel ? obs_b : obs_a;
        compared++;
        if (got !== e.exp) begin
            failed++;
            $display("[TB] FAIL %s: got ctl=%b fa=%b fb=%b fid=%b%b busy=%b cnt=%0d, expected ctl=%b fa=%b fb=%b fid=%b%b busy=%b cnt=%0d",
                     e.name, got.ctl, got.fa, got.fb, got.fia, got.fib, got.busy, got.cnt,
                     e.exp.ctl, e.exp.fa, e.exp.fb, e.exp.fia, e.exp.fib, e.exp.busy, e.exp.cnt);
        end
    endtask

    always @(negedge clk) begin
        if (sb_q.size() != 0) begin
            checkOutput(sb_q.pop_front());
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached, %0d entries pending", sb_q.size());
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        in_t v;
        reset_a = 1'b0;
        reset_b = 1'b0;
        driveIf(1'b0, '0);
        driveIf(1'b1, '0);
        @(posedge clk);
        #1;

        // Reset forces every output low, even with hazards on the inputs.
        v = '0; v.ex_rs = 3; v.mem_rd = 3; v.mem_regwrite = 1;
        v.ex_memread = 1; v.ex_rd = 5; v.id_rs = 5;
        applyStimulus("reset_a_forced_zero", 0, 0, v, NONE, FWD_RF, FWD_RF, 0, 0, 0, 0);
        v = '0;
        applyStimulus("reset_b_idle", 1, 0, v, NONE, FWD_RF, FWD_RF, 0, 0, 0, 0);

        // EX forwarding on the single-cycle-memory instance.
        v = '0; v.ex_rs = 3; v.mem_rd = 3; v.mem_regwrite = 1; v.wb_rd = 3; v.wb_regwrite = 1;
        applyStimulus("fwd_a_mem_prio", 0, 1, v, NONE, FWD_MEM, FWD_RF, 0, 0, 0, 0);
        v.mem_rd = 0;
        applyStimulus("fwd_a_wb_mem_r0", 0, 1, v, NONE, FWD_WB, FWD_RF, 0, 0, 0, 0);
        v = '0; v.ex_rs = 7; v.ex_rt = 7; v.wb_rd = 7; v.wb_regwrite = 1; v.mem_rd = 7;
        applyStimulus("fwd_ab_wb", 0, 1, v, NONE, FWD_WB, FWD_WB, 0, 0, 0, 0);
        v = '0; v.mem_regwrite = 1; v.wb_regwrite = 1;
        applyStimulus("fwd_r0_never", 0, 1, v, NONE, FWD_RF, FWD_RF, 0, 0, 0, 0);

        // Load-use stalls.
        v = '0; v.ex_memread = 1; v.ex_regwrite = 1; v.ex_rd = 5; v.id_rs = 5; v.id_jump = 1;
        applyStimulus("load_use_rs_over_jump", 0, 1, v, STALL, FWD_RF, FWD_RF, 0, 0, 0, 0);
        v = '0; v.ex_rs = 5; v.wb_rd = 5; v.wb_regwrite = 1;
        applyStimulus("after_load_use_fwd_wb", 0, 1, v, NONE, FWD_WB, FWD_RF, 0, 0, 0, 1);
        v = '0; v.ex_memread = 1; v.ex_regwrite = 1; v.ex_rd = 6; v.id_rt = 6; v.id_rs = 1;
        applyStimulus("no_use_rt", 0, 1, v, NONE, FWD_RF, FWD_RF, 0, 0, 0, 1);
        v.id_use_rt = 1;
        applyStimulus("load_use_rt", 0, 1, v, STALL, FWD_RF, FWD_RF, 0, 0, 0, 1);
        v = '0; v.ex_memread = 1; v.ex_regwrite = 1;
        applyStimulus("load_r0", 0, 1, v, NONE, FWD_RF, FWD_RF, 0, 0, 0, 2);

        // beq $4,$2 behind lw $4: two stalls, then taken flush.
        v = '0; v.id_branch = 1; v.id_taken = 1; v.id_rs = 4; v.id_rt = 2; v.id_use_rt = 1;
        v.ex_memread = 1; v.ex_regwrite = 1; v.ex_rd = 4;
        applyStimulus("beq_lw_stall1", 0, 1, v, STALL, FWD_RF, FWD_RF, 0, 0, 0, 2);
        v.ex_memread = 0; v.ex_regwrite = 0; v.ex_rd = 0;
        v.mem_rd = 4; v.mem_memread = 1; v.mem_regwrite = 1;
        applyStimulus("beq_lw_stall2", 0, 1, v, STALL, FWD_RF, FWD_RF, 0, 0, 0, 3);
        v.mem_rd = 0; v.mem_memread = 0; v.mem_regwrite = 0; v.wb_rd = 4; v.wb_regwrite = 1;
        applyStimulus("beq_lw_resolve_flush", 0, 1, v, FLUSH, FWD_RF, FWD_RF, 0, 0, 0, 4);

        // beq $4,$2 behind add $4: one stall, then ID forwarding.
        v = '0; v.id_branch = 1; v.id_rs = 4; v.id_rt = 2; v.id_use_rt = 1;
        v.ex_regwrite = 1; v.ex_rd = 4;
        applyStimulus("beq_alu_stall", 0, 1, v, STALL, FWD_RF, FWD_RF, 0, 0, 0, 4);
        v.ex_regwrite = 0; v.ex_rd = 0; v.mem_rd = 4; v.mem_regwrite = 1; v.id_taken = 1;
        applyStimulus("beq_alu_fwd_id", 0, 1, v, FLUSH, FWD_RF, FWD_RF, 1, 0, 0, 5);
        v = '0; v.id_rs = 9; v.id_rt = 2; v.mem_rd = 2; v.mem_regwrite = 1;
        applyStimulus("fwd_id_b", 0, 1, v, NONE, FWD_RF, FWD_RF, 0, 1, 0, 5);
        v = '0; v.id_jump = 1;
        applyStimulus("jump_flush", 0, 1, v, FLUSH, FWD_RF, FWD_RF, 0, 0, 0, 5);
        v = '0; v.mem_memread = 1; v.mem_regwrite = 1; v.mem_rd = 8; v.ex_rs = 8;
        applyStimulus("lat1_no_freeze", 0, 1, v, NONE, FWD_MEM, FWD_RF, 0, 0, 0, 5);
        applyStimulus("lat1_no_freeze_2", 0, 1, v, NONE, FWD_MEM, FWD_RF, 0, 0, 0, 5);

        // MEM_LAT=4: lw in MEM with a load-use behind it and a jump in ID.
        v = '0; v.mem_memread = 1; v.mem_regwrite = 1; v.mem_rd = 5;
        v.ex_memread = 1; v.ex_regwrite = 1; v.ex_rd = 6; v.id_rs = 6; v.id_jump = 1;
        applyStimulus("lat4_freeze_idle", 1, 1, v, FREEZE, FWD_RF, FWD_RF, 0, 0, 0, 0);
        applyStimulus("lat4_wait1", 1, 1, v, FREEZE, FWD_RF, FWD_RF, 0, 0, 1, 1);
        applyStimulus("lat4_wait2", 1, 1, v, FREEZE, FWD_RF, FWD_RF, 0, 0, 1, 2);
        applyStimulus("lat4_release_bubble", 1, 1, v, STALL, FWD_RF, FWD_RF, 0, 0, 0, 3);

        // Next access enters MEM, then reset hits in its second WAIT cycle.
        v = '0; v.mem_memread = 1; v.mem_regwrite = 1; v.mem_rd = 6; v.ex_rs = 6;
        applyStimulus("lat4_next_access", 1, 1, v, FREEZE, FWD_MEM, FWD_RF, 0, 0, 0, 4);
        applyStimulus("lat4_next_wait1", 1, 1, v, FREEZE, FWD_MEM, FWD_RF, 0, 0, 1, 5);
        applyStimulus("lat4_reset_in_wait", 1, 0, v, NONE, FWD_RF, FWD_RF, 0, 0, 0, 0);
        v = '0;
        applyStimulus("post_reset_idle", 1, 1, v, NONE, FWD_RF, FWD_RF, 0, 0, 0, 0);

        // Store access: full freeze and no re-trigger on release.
        v = '0; v.mem_memwrite = 1;
        applyStimulus("sw_freeze", 1, 1, v, FREEZE, FWD_RF, FWD_RF, 0, 0, 0, 0);
        applyStimulus("sw_wait1", 1, 1, v, FREEZE, FWD_RF, FWD_RF, 0, 0, 1, 1);
        applyStimulus("sw_wait2", 1, 1, v, FREEZE, FWD_RF, FWD_RF, 0, 0, 1, 2);
        applyStimulus("sw_release_no_retrigger", 1, 1, v, NONE, FWD_RF, FWD_RF, 0, 0, 0, 3);
        v = '0;
        applyStimulus("sw_after", 1, 1, v, NONE, FWD_RF, FWD_RF, 0, 0, 0, 3);

        // 20 consecutive stall cycles on the 4-bit counter: 3 climbs to 15 and sticks.
        v = '0; v.ex_memread = 1; v.ex_regwrite = 1; v.ex_rd = 5; v.id_rs = 5;
        for (int k = 0; k < 20; k++) begin
            applyStimulus($sformatf("sat_stall_%0d", k), 1, 1, v, STALL, FWD_RF, FWD_RF, 0, 0, 0,
                          (3 + k > 15) ? 15 : 3 + k);
        end
        v = '0;
        applyStimulus("sat_hold", 1, 1, v, NONE, FWD_RF, FWD_RF, 0, 0, 0, 15);

        compared++;
        if (sb_q.size() != 0) begin
            failed++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending entries, expected 0", sb_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule
